// File: rtl/config_chain_loader.sv
// rtl/config_chain_loader.sv - writer end of the tile configuration shift chain
//
// Purpose: accepts bitstream words from a host over a valid/ready handshake and
// serialises them MSB first into a tile config chain. Before loading, the chain
// is cleared by holding chain_nreset low. busy/done/error report progress.
// Optional CRC-16-CCITT check over the shifted bits is compiled in when the
// macro CONFIG_LOADER_CRC_EN is defined; otherwise error is tied low.
//
// Ports:
//   clock        in   single clock; the chain shifts on the same edge
//   reset        in   asynchronous, active-high
//   start        in   begin a load (honoured in IDLE/DONE only)
//   word_data    in   host word, MSB shifted first
//   word_valid   in   host word valid
//   word_ready   out  loader accepts a word this cycle
//   chain_data   out  serial bit to tile config_in (0 when not shifting)
//   chain_enable out  shift strobe to tile config_enable
//   chain_nreset out  active-low chain clear to tile config_nreset
//   busy         out  load in progress
//   done         out  load complete (level, held until next start)
//   error        out  CRC mismatch (level)
module config_chain_loader #(
  parameter int WORD_WIDTH   = 8,
  parameter int CHAIN_LENGTH = 36,
  parameter int CLEAR_CYCLES = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] word_data,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic                  chain_data,
  output logic                  chain_enable,
  output logic                  chain_nreset,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int CNT_W = $clog2(CHAIN_LENGTH + 1);
  localparam int BIT_W = $clog2(WORD_WIDTH + 1);
  localparam int CLR_W = $clog2(CLEAR_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_WAIT_WORD,
    S_SHIFT,
    S_CHECK,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      remaining_q, remaining_d;
  logic [BIT_W-1:0]      word_bits_q, word_bits_d;
  logic [CLR_W-1:0]      clr_cnt_q, clr_cnt_d;
  logic [WORD_WIDTH-1:0] shreg_q, shreg_d;

`ifdef CONFIG_LOADER_CRC_EN
  localparam int CRC_WORDS = (16 + WORD_WIDTH - 1) / WORD_WIDTH;
  localparam int CRC_CNT_W = $clog2(CRC_WORDS + 1);

  logic [15:0]          crc_q, crc_d;
  logic [15:0]          crc_exp_q, crc_exp_d;
  logic [CRC_CNT_W-1:0] crc_cnt_q, crc_cnt_d;
  logic                 error_q, error_d;
  logic                 crc_fb;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      word_bits_q <= '0;
      clr_cnt_q   <= '0;
      shreg_q     <= '0;
`ifdef CONFIG_LOADER_CRC_EN
      crc_q       <= 16'hFFFF;
      crc_exp_q   <= '0;
      crc_cnt_q   <= '0;
      error_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      word_bits_q <= word_bits_d;
      clr_cnt_q   <= clr_cnt_d;
      shreg_q     <= shreg_d;
`ifdef CONFIG_LOADER_CRC_EN
      crc_q       <= crc_d;
      crc_exp_q   <= crc_exp_d;
      crc_cnt_q   <= crc_cnt_d;
      error_q     <= error_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    word_bits_d = word_bits_q;
    clr_cnt_d   = clr_cnt_q;
    shreg_d     = shreg_q;
`ifdef CONFIG_LOADER_CRC_EN
    crc_d       = crc_q;
    crc_exp_d   = crc_exp_q;
    crc_cnt_d   = crc_cnt_q;
    error_d     = error_q;
    crc_fb      = crc_q[15] ^ shreg_q[WORD_WIDTH-1];
`endif
    word_ready   = 1'b0;
    chain_data   = 1'b0;
    chain_enable = 1'b0;
    chain_nreset = 1'b1;
    busy         = 1'b0;
    done         = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        done = (state_q == S_DONE);
        if (start) begin
          state_d     = S_CLEAR;
          remaining_d = CNT_W'(CHAIN_LENGTH);
          clr_cnt_d   = CLR_W'(CLEAR_CYCLES);
`ifdef CONFIG_LOADER_CRC_EN
          crc_d       = 16'hFFFF;
          crc_cnt_d   = '0;
          error_d     = 1'b0;
`endif
        end
      end

      S_CLEAR: begin
        busy         = 1'b1;
        chain_nreset = 1'b0;
        clr_cnt_d    = clr_cnt_q - CLR_W'(1);
        if (clr_cnt_q <= CLR_W'(1)) begin
          state_d = S_WAIT_WORD;
        end
      end

      S_WAIT_WORD: begin
        busy       = 1'b1;
        word_ready = 1'b1;
        if (word_valid) begin
          shreg_d     = word_data;
          word_bits_d = BIT_W'(WORD_WIDTH);
          state_d     = S_SHIFT;
        end
      end

      S_SHIFT: begin
        busy         = 1'b1;
        chain_enable = 1'b1;
        chain_data   = shreg_q[WORD_WIDTH-1];
        shreg_d      = shreg_q << 1;
        word_bits_d  = word_bits_q - BIT_W'(1);
        // Saturating count: never wraps even if the state were corrupted.
        remaining_d  = (remaining_q != '0) ? remaining_q - CNT_W'(1) : '0;
`ifdef CONFIG_LOADER_CRC_EN
        crc_d        = {crc_q[14:0], 1'b0} ^ (crc_fb ? 16'h1021 : 16'h0000);
`endif
        // The final word may be partial: its unused LSBs are never shifted.
        if (remaining_q <= CNT_W'(1)) begin
`ifdef CONFIG_LOADER_CRC_EN
          state_d = S_CHECK;
`else
          state_d = S_DONE;
`endif
        end else if (word_bits_q <= BIT_W'(1)) begin
          state_d = S_WAIT_WORD;
        end
      end

`ifdef CONFIG_LOADER_CRC_EN
      S_CHECK: begin
        busy       = 1'b1;
        word_ready = 1'b1;
        if (word_valid) begin
          // Words concatenate MSB first; only the low 16 bits form the CRC.
          crc_exp_d = (crc_exp_q << WORD_WIDTH) | 16'(word_data);
          crc_cnt_d = crc_cnt_q + CRC_CNT_W'(1);
          if (crc_cnt_q == CRC_CNT_W'(CRC_WORDS - 1)) begin
            error_d = (crc_exp_d != crc_q);
            state_d = S_DONE;
          end
        end
      end
`endif

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

`ifdef CONFIG_LOADER_CRC_EN
  assign error = error_q;
`else
  assign error = 1'b0;
`endif

endmodule

// File: tb/tb_config_chain_loader.sv
// tb/tb_config_chain_loader.sv - self-checking bench for config_chain_loader
module tb_config_chain_loader;

  localparam int WW     = 8;
  localparam int CL     = 36;
  localparam int CC     = 2;
  localparam int NWORDS = (CL + WW - 1) / WW;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [WW-1:0] word_data = '0;
  logic          word_valid = 1'b0;
  logic          word_ready;
  logic          chain_data;
  logic          chain_enable;
  logic          chain_nreset;
  logic          busy;
  logic          done;
  logic          error;

  int checks = 0;
  int errors = 0;

  bit            stream[$];
  int            nreset_low = 0;
  int            data_viol  = 0;
  int            cyc        = 0;
  int            first_en   = 0;
  int            last_en    = 0;
  logic [CL-1:0] tile_sr    = '0;
  logic [WW-1:0] cur_words[NWORDS];

  always #5 clock = ~clock;

  config_chain_loader #(
    .WORD_WIDTH  (WW),
    .CHAIN_LENGTH(CL),
    .CLEAR_CYCLES(CC)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .word_data   (word_data),
    .word_valid  (word_valid),
    .word_ready  (word_ready),
    .chain_data  (chain_data),
    .chain_enable(chain_enable),
    .chain_nreset(chain_nreset),
    .busy        (busy),
    .done        (done),
    .error       (error)
  );

  // Chain observer and tile model: the tile captures config_in on each enabled cycle.
  always @(negedge clock) begin
    cyc <= cyc + 1;
    if (chain_enable === 1'b1) begin
      if (stream.size() == 0) first_en <= cyc;
      last_en <= cyc;
      stream.push_back(chain_data);
      tile_sr <= {tile_sr[CL-2:0], chain_data};
    end else if (chain_data !== 1'b0) begin
      data_viol <= data_viol + 1;
    end
    if (chain_nreset === 1'b0) begin
      nreset_low <= nreset_low + 1;
      tile_sr    <= '0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference: concatenate the words and keep the first CL bits.
  function automatic logic [CL-1:0] ref_chain();
    logic [NWORDS*WW-1:0] all;
    all = '0;
    for (int i = 0; i < NWORDS; i++) all = (all << WW) | (NWORDS*WW)'(cur_words[i]);
    return CL'(all >> (NWORDS*WW - CL));
  endfunction

  function automatic logic [15:0] ref_crc(input logic [CL-1:0] bits);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = CL - 1; i >= 0; i--) begin
      if (c[15] ^ bits[i]) c = (c << 1) ^ 16'h1021;
      else                 c = c << 1;
    end
    return c;
  endfunction

  task automatic set_fixed_words();
    cur_words[0] = 8'hA5;
    cur_words[1] = 8'h3C;
    cur_words[2] = 8'hFF;
    cur_words[3] = 8'h00;
    cur_words[4] = 8'h9F;
  endtask

  task automatic set_random_words();
    for (int i = 0; i < NWORDS; i++) cur_words[i] = WW'($urandom);
  endtask

  // Called at posedge+1. gap>0: wait for ready, hold valid low for gap cycles, then offer.
  task automatic send_word(input logic [WW-1:0] w, input int gap);
    int n;
    n = 0;
    if (gap > 0) begin
      while (word_ready !== 1'b1 && n < 200) begin @(posedge clock); #1; n++; end
      repeat (gap) begin @(posedge clock); #1; end
    end
    word_valid = 1'b1;
    word_data  = w;
    while (word_ready !== 1'b1 && n < 400) begin @(posedge clock); #1; n++; end
    @(posedge clock); #1;
    word_valid = 1'b0;
    word_data  = WW'($urandom);
    checks++;
    if (n >= 400) begin
      errors++;
      $display("FAIL send_word_timeout: word_ready=%b required 1", word_ready);
    end
  endtask

  task automatic do_load(input string name, input int gap, input bit glitch, input bit corrupt);
    logic [CL-1:0] exp_chain;
    logic [CL-1:0] act;
    logic          exp_err;
    int            n;
    int            g;
    exp_chain  = ref_chain();
    stream.delete();
    nreset_low = 0;
    data_viol  = 0;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || error !== 1'b0) begin
      errors++;
      $display("FAIL %s start_ack: busy=%b done=%b error=%b required 1 0 0", name, busy, done, error);
    end
    for (int i = 0; i < NWORDS; i++) begin
      if (glitch && i == 2) begin
        start = 1'b1;
        repeat (3) begin @(posedge clock); #1; end
        start = 1'b0;
      end
      g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
      send_word(cur_words[i], g);
    end
`ifdef CONFIG_LOADER_CRC_EN
    begin
      logic [15:0] crc;
      crc = ref_crc(exp_chain);
      if (corrupt) crc[0] = ~crc[0];
      send_word(crc[15:8], (gap < 0) ? 0 : gap);
      send_word(crc[7:0], (gap < 0) ? 0 : gap);
      exp_err = corrupt;
    end
`else
    exp_err = 1'b0;
`endif
    n = 0;
    while (done !== 1'b1 && n < 300) begin @(posedge clock); #1; n++; end
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL %s done_timeout: done=%b required 1", name, done);
    end
    @(posedge clock); #1;
    checks++;
    if (stream.size() != CL) begin
      errors++;
      $display("FAIL %s enable_pulses: got %0d required %0d", name, stream.size(), CL);
    end
    act = '0;
    foreach (stream[i]) act = {act[CL-2:0], stream[i]};
    checks++;
    if (act !== exp_chain) begin
      errors++;
      $display("FAIL %s serial_stream: got %h required %h", name, act, exp_chain);
    end
    checks++;
    if (tile_sr !== exp_chain) begin
      errors++;
      $display("FAIL %s tile_contents: got %h required %h", name, tile_sr, exp_chain);
    end
    checks++;
    if (nreset_low != CC || data_viol != 0) begin
      errors++;
      $display("FAIL %s clear_and_idle_data: nreset_low=%0d data_viol=%0d required %0d 0", name, nreset_low, data_viol, CC);
    end
    if (gap >= 0 && !glitch) begin
      checks++;
      if (last_en - first_en + 1 != CL + (NWORDS - 1) * (gap + 1)) begin
        errors++;
        $display("FAIL %s stream_span: got %0d required %0d", name, last_en - first_en + 1, CL + (NWORDS - 1) * (gap + 1));
      end
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || word_ready !== 1'b0 || error !== exp_err) begin
      errors++;
      $display("FAIL %s done_state: done=%b busy=%b ready=%b error=%b required 1 0 0 %b", name, done, busy, word_ready, error, exp_err);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (word_ready !== 1'b0 || chain_data !== 1'b0 || chain_enable !== 1'b0 || chain_nreset !== 1'b1 ||
        busy !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin
      errors++;
      $display("FAIL %s reset_outputs: ready=%b data=%b en=%b nreset=%b busy=%b done=%b error=%b required 0 0 0 1 0 0 0",
               name, word_ready, chain_data, chain_enable, chain_nreset, busy, done, error);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_reset_outputs("reset_held");
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check_reset_outputs("reset_released");
    @(posedge clock); #1;
  endtask

  task automatic test_basic_load();
    set_fixed_words();
    do_load("basic", 0, 1'b0, 1'b0);
    checks++;
    if (tile_sr !== 36'hA53CFF009) begin
      errors++;
      $display("FAIL basic chain_constant: got %h required a53cff009", tile_sr);
    end
  endtask

  task automatic test_gapped_load();
    set_fixed_words();
    do_load("gapped", 3, 1'b0, 1'b0);
  endtask

  task automatic test_start_while_busy();
    set_fixed_words();
    do_load("start_busy", 0, 1'b1, 1'b0);
    set_random_words();
    do_load("restart_from_done", 1, 1'b0, 1'b0);
  endtask

  task automatic test_random_loads();
    for (int k = 0; k < 4; k++) begin
      set_random_words();
      do_load($sformatf("random%0d", k), (k % 2 == 0) ? -1 : k, 1'b0, 1'b0);
    end
  endtask

  task automatic test_reset_mid_shift();
    logic [CL-1:0] exp_chain;
    logic [9:0]    first10;
    int            n;
    int            bad;
    set_fixed_words();
    exp_chain = ref_chain();
    stream.delete();
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    send_word(cur_words[0], 0);
    send_word(cur_words[1], 0);
    n = 0;
    while (stream.size() < 10 && n < 100) begin @(posedge clock); #1; n++; end
    first10 = '0;
    for (int i = 0; i < 10 && i < stream.size(); i++) first10 = {first10[8:0], stream[i]};
    checks++;
    if (n >= 100 || first10 !== exp_chain[CL-1:CL-10]) begin
      errors++;
      $display("FAIL mid_shift first_bits: got %b required %b", first10, exp_chain[CL-1:CL-10]);
    end
    reset = 1'b1;
    @(negedge clock);
    check_reset_outputs("mid_shift");
    @(posedge clock); #1;
    reset = 1'b0;
    // Without start the loader must stay idle even with a word offered.
    word_valid = 1'b1;
    bad = 0;
    repeat (4) begin
      @(negedge clock);
      if (word_ready !== 1'b0 || busy !== 1'b0 || chain_enable !== 1'b0) bad++;
    end
    @(posedge clock); #1;
    word_valid = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL mid_shift stays_idle: active cycles=%0d required 0", bad);
    end
    set_random_words();
    do_load("after_reset", 0, 1'b0, 1'b0);
  endtask

`ifdef CONFIG_LOADER_CRC_EN
  task automatic test_crc();
    set_fixed_words();
    do_load("crc_good", 0, 1'b0, 1'b0);
    set_fixed_words();
    do_load("crc_bad", 0, 1'b0, 1'b1);
    set_random_words();
    do_load("crc_random_good", 2, 1'b0, 1'b0);
  endtask
`endif

  initial begin
    test_reset();
    test_basic_load();
    test_gapped_load();
    test_start_while_busy();
    test_random_loads();
    test_reset_mid_shift();
`ifdef CONFIG_LOADER_CRC_EN
    test_crc();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
